// File: rtl/magma_encoder_iter.sv
// Iterative Magma (GOST R 34.12-2015, 64-bit block) encryptor: one Feistel round
// per clock, 32 rounds, valid/ready handshake on both sides.
module magma_encoder_iter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  block,
  input  logic [255:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  encoded
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [4:0]     rnd_q, rnd_d;
  logic [31:0]    hi_q, hi_d;
  logic [31:0]    lo_q, lo_d;
  logic [255:0]   key_q, key_d;

  logic [2:0]     kidx;
  logic [31:0]    rk;
  logic [31:0]    sum;
  logic [31:0]    sub;
  logic [31:0]    g;
  logic           accept;

  // Each table holds entry 0 in its least-significant nibble.
  function automatic logic [3:0] sbox(input logic [2:0] idx, input logic [3:0] x);
    logic [63:0] tbl;
    unique case (idx)
      3'd0: tbl = 64'h1F307D8E9B5A264C;
      3'd1: tbl = 64'hF0DB74E1C5A93286;
      3'd2: tbl = 64'h069C471EDAF2853B;
      3'd3: tbl = 64'hB9E35A076F4D128C;
      3'd4: tbl = 64'hC24BE390D618A5F7;
      3'd5: tbl = 64'h0E34187BAC296FD5;
      3'd6: tbl = 64'h73AD0B4FC19652E8;
      3'd7: tbl = 64'h2BC96AF43850DE71;
      default: tbl = '0;
    endcase
    return tbl[{x, 2'b00} +: 4];
  endfunction

  // K1 sits in the top word of the key; rounds 0..23 walk K1..K8, 24..31 walk K8..K1.
  always_comb begin
    kidx = (rnd_q < 5'd24) ? ~rnd_q[2:0] : rnd_q[2:0];
    rk   = key_q[{kidx, 5'b00000} +: 32];
    sum  = lo_q + rk;
    sub  = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      sub[4*i +: 4] = sbox(i[2:0], sum[4*i +: 4]);
    end
    g = {sub[20:0], sub[31:21]};
  end

  always_comb begin
    in_ready = rst_n && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    accept   = in_valid && in_ready;

    state_d = state_q;
    rnd_d   = rnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    key_d   = key_q;

    unique case (state_q)
      RUN: begin
        rnd_d = rnd_q + 5'd1;
        if (rnd_q == 5'd31) begin
          hi_d    = g ^ hi_q;
          state_d = DONE;
        end else begin
          hi_d = lo_q;
          lo_d = g ^ hi_q;
        end
      end
      DONE: begin
        if (out_ready && !in_valid) state_d = IDLE;
      end
      default: ;
    endcase

    if (accept) begin
      state_d = RUN;
      rnd_d   = '0;
      hi_d    = block[63:32];
      lo_d    = block[31:0];
      key_d   = key;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      key_q   <= key_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign encoded   = {hi_q, lo_q};

endmodule

// File: tb/tb_magma_encoder_iter.sv
// Self-checking bench for magma_encoder_iter: transaction-level reference model,
// per-cycle comparison, directed standard vectors and randomized traffic.
module tb_magma_encoder_iter;

  localparam logic [255:0] KEY = 256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [63:0]  B1  = 64'hfedcba9876543210;
  localparam logic [63:0]  E1  = 64'h4ee901e5c2d8ca3d;
  localparam logic [63:0]  B2  = 64'h92def06b3c130a59;
  localparam logic [63:0]  E2  = 64'h2b073f0494f372a0;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [63:0]  block = '0;
  logic [255:0] key = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [63:0]  encoded;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  magma_encoder_iter dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .block(block), .key(key), .out_valid(out_valid), .out_ready(out_ready),
    .encoded(encoded)
  );

  byte unsigned PI [8][16] = '{
    '{12, 4, 6, 2,10, 5,11, 9,14, 8,13, 7, 0, 3,15, 1},
    '{ 6, 8, 2, 3, 9,10, 5,12, 1,14, 4, 7,11,13, 0,15},
    '{11, 3, 5, 8, 2,15,10,13,14, 1, 7, 4,12, 9, 6, 0},
    '{12, 8, 2, 1,13, 4,15, 6, 7, 0,10, 5, 3,14, 9,11},
    '{ 7,15, 5,10, 8, 1, 6,13, 0, 9, 3,14,11, 4, 2,12},
    '{ 5,13,15, 6, 9, 2,12,10,11, 7, 8, 1, 4, 3,14, 0},
    '{ 8,14, 2, 5, 6, 9, 1,12,15, 4,11, 0,13,10, 3, 7},
    '{ 1, 7,14,13, 0, 5, 8, 3, 4,15,10, 6, 9,12,11, 2}
  };

  function automatic logic [31:0] gfun(input logic [31:0] a, input logic [31:0] k);
    logic [31:0] x, s;
    x = a + k;
    s = 0;
    for (int i = 0; i < 8; i++)
      s = s | (32'(PI[i][(x >> (4*i)) & 32'hf]) << (4*i));
    return (s << 11) | (s >> 21);
  endfunction

  // Whole-block Magma; decryption runs the encryption key schedule backwards.
  function automatic logic [63:0] crypt(input logic [63:0] b, input logic [255:0] k, input bit dec);
    logic [31:0] kw [8];
    logic [31:0] sched [32];
    logic [31:0] a1, a0, t;
    for (int i = 0; i < 8; i++) kw[i] = k[255 - 32*i -: 32];
    for (int r = 0; r < 32; r++) sched[r] = (r < 24) ? kw[r % 8] : kw[7 - (r % 8)];
    a1 = b[63:32];
    a0 = b[31:0];
    for (int r = 0; r < 32; r++) begin
      t = gfun(a0, dec ? sched[31 - r] : sched[r]) ^ a1;
      if (r == 31) a1 = t;
      else begin a1 = a0; a0 = t; end
    end
    return {a1, a0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a block is pending from its accept edge until handed off;
  // its result is due 32 edges after acceptance.
  int          cyc = 0;
  int          acc_cyc = 0;
  bit          pending = 1'b0;
  logic [63:0] exp_res = '0;
  logic        m_done, exp_ready;

  assign m_done    = pending && ((cyc - acc_cyc) >= 32);
  assign exp_ready = rst_n && (!pending || (m_done && out_ready));

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) pending <= 1'b0;
    else begin
      if (m_done && out_ready) pending <= 1'b0;
      if (in_valid && exp_ready) begin
        pending <= 1'b1;
        acc_cyc <= cyc + 1;
        exp_res <= crypt(block, key, 1'b0);
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_in_ready", 64'(in_ready), 64'(exp_ready));
    chk("cyc_out_valid", 64'(out_valid), 64'(m_done));
    if (m_done) chk("cyc_encoded", encoded, exp_res);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ov(input int budget, input string name);
    int n = 0;
    while (!out_valid && n < budget) begin tick(); n++; end
    if (!out_valid) chk(name, 64'(out_valid), 64'd1);
  endtask

  initial begin
    bit seen;
    chk("model_v1", crypt(B1, KEY, 1'b0), E1);
    chk("model_v2", crypt(B2, KEY, 1'b0), E2);
    chk("model_dec", crypt(E1, KEY, 1'b1), B1);

    // Reset state
    repeat (3) tick();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_encoded", encoded, 64'h0);
    rst_n = 1'b1;
    #1 chk("ready_after_reset", 64'(in_ready), 64'd1);

    // Standard vector with inputs corrupted after acceptance
    in_valid = 1'b1; block = B1; key = KEY;
    tick();
    in_valid = 1'b0; block = '0; key = '0;
    repeat (31) tick();
    chk("ov_before_32", 64'(out_valid), 64'd0);
    tick();
    chk("ov_at_32", 64'(out_valid), 64'd1);
    chk("v1_encoded", encoded, E1);
    chk("e2e_decode", crypt(encoded, KEY, 1'b1), B1);

    // Back-pressure
    repeat (10) tick();
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    chk("bp_encoded", encoded, E1);
    chk("bp_in_ready", 64'(in_ready), 64'd0);

    // Back-to-back hand-off with the second vector queued
    in_valid = 1'b1; block = B2; key = KEY; out_ready = 1'b1;
    #1 chk("b2b_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_ov_dropped", 64'(out_valid), 64'd0);
    repeat (31) tick();
    chk("b2b_ov_before_32", 64'(out_valid), 64'd0);
    tick();
    chk("b2b_ov_at_32", 64'(out_valid), 64'd1);
    chk("v2_encoded", encoded, E2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hs_ov_low", 64'(out_valid), 64'd0);
    chk("hs_in_ready", 64'(in_ready), 64'd1);

    // Mid-run reset at round 15
    in_valid = 1'b1; block = B1; key = KEY;
    tick();
    in_valid = 1'b0;
    repeat (15) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_encoded", encoded, 64'h0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin tick(); if (out_valid) seen = 1'b1; end
    chk("abort_no_ov", 64'(seen), 64'd0);
    in_valid = 1'b1; block = B1; key = KEY;
    tick();
    in_valid = 1'b0;
    wait_ov(40, "post_reset_timeout");
    chk("post_reset_v1", encoded, E1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Randomized traffic with occasional resets
    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rst_n     = ($urandom_range(0, 699) != 0);
      block     = {$urandom, $urandom};
      key       = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      tick();
    end
    rst_n = 1'b1; in_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
